// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter. It issues a zero-latency one-hot grant each cycle.
// Per-FU wait counters let a starved requester override the rotating pointer.
module cdb_arbiter #(
  parameter int FU_NUM = 5,
  parameter int WAIT_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [FU_NUM-1:0] fu_req,
  input  logic              cdb_stall,
  input  logic              squash,
  output logic              select_flag,
  output logic [FU_NUM-1:0] select_signal,
  output logic [FU_NUM-1:0] fu_ack,
  output logic [FU_NUM-1:0] starve_flag
);

  localparam int PTR_W = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
  localparam logic [WAIT_W-1:0] CNT_MAX = {WAIT_W{1'b1}};
  localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(FU_NUM - 1);

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WAIT_W-1:0] wait_cnt_q [FU_NUM];
  logic [WAIT_W-1:0] wait_cnt_d [FU_NUM];
  logic [FU_NUM-1:0] starve_flag_q, starve_flag_d;

  logic              en;
  logic [FU_NUM-1:0] sat;
  logic [FU_NUM-1:0] grant;
  logic [PTR_W-1:0]  gnt_idx;
  logic              gnt_valid;

  assign en = reset_n & ~cdb_stall & ~squash & (|fu_req);

  always_comb begin
    for (int i = 0; i < FU_NUM; i++) begin
      sat[i] = (wait_cnt_q[i] == CNT_MAX);
    end
  end

  // Scans run high-to-low so the last hit written is the highest-priority one.
  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    if (en) begin
      for (int i = FU_NUM - 1; i >= 0; i--) begin
        if (fu_req[i] && sat[i]) begin
          gnt_idx   = PTR_W'(i);
          gnt_valid = 1'b1;
        end else begin
          gnt_valid = gnt_valid;
        end
      end
      if (!gnt_valid) begin
        for (int k = FU_NUM - 1; k >= 0; k--) begin
          j = int'(rr_ptr_q) + k;
          if (j >= FU_NUM) begin
            j = j - FU_NUM;
          end else begin
            j = j;
          end
          if (fu_req[j[PTR_W-1:0]]) begin
            gnt_idx   = j[PTR_W-1:0];
            gnt_valid = 1'b1;
          end else begin
            gnt_valid = gnt_valid;
          end
        end
      end else begin
        gnt_idx = gnt_idx;
      end
    end else begin
      gnt_valid = 1'b0;
    end
    if (gnt_valid) begin
      grant[gnt_idx] = 1'b1;
    end else begin
      grant = '0;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (squash) begin
      rr_ptr_d = '0;
    end else if (gnt_valid) begin
      rr_ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    for (int i = 0; i < FU_NUM; i++) begin
      if (squash || !fu_req[i] || grant[i]) begin
        wait_cnt_d[i] = '0;
      end else if (sat[i]) begin
        wait_cnt_d[i] = wait_cnt_q[i];
      end else begin
        wait_cnt_d[i] = wait_cnt_q[i] + WAIT_W'(1);
      end
      starve_flag_d[i] = (wait_cnt_d[i] == CNT_MAX);
    end
  end

  // starve_flag_q tracks the saturation decode of the counters it is loaded with.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q      <= '0;
      starve_flag_q <= '0;
      for (int i = 0; i < FU_NUM; i++) begin
        wait_cnt_q[i] <= '0;
      end
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      starve_flag_q <= starve_flag_d;
      for (int i = 0; i < FU_NUM; i++) begin
        wait_cnt_q[i] <= wait_cnt_d[i];
      end
    end
  end

  assign select_signal = grant;
  assign fu_ack        = grant;
  assign select_flag   = |grant;
  assign starve_flag   = starve_flag_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scenario-driven bench for cdb_arbiter: expected grants are queued as stimulus
// is applied and popped when the combinational grant is sampled mid-cycle.
module tb_cdb_arbiter;

  logic       clock;
  logic       reset_n;
  logic [4:0] fu_req;
  logic       cdb_stall;
  logic       squash;
  logic       select_flag;
  logic [4:0] select_signal;
  logic [4:0] fu_ack;
  logic [4:0] starve_flag;

  int n_checks;
  int n_fails;
  logic [4:0] exp_q [$];

  cdb_arbiter #(.FU_NUM(5), .WAIT_W(4)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .fu_req       (fu_req),
    .cdb_stall    (cdb_stall),
    .squash       (squash),
    .select_flag  (select_flag),
    .select_signal(select_signal),
    .fu_ack       (fu_ack),
    .starve_flag  (starve_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Drive one cycle of inputs, queue the expected grant, compare at negedge.
  task automatic step(input logic [4:0] req, input logic st, input logic sq,
                      input logic [4:0] exp, input string name);
    logic [4:0] want;
    fu_req    = req;
    cdb_stall = st;
    squash    = sq;
    exp_q.push_back(exp);
    @(negedge clock);
    want = exp_q.pop_front();
    n_checks++;
    if (select_signal !== want) begin
      n_fails++;
      $display("FAIL %s select_signal: got %b expected %b", name, select_signal, want);
    end
    n_checks++;
    if (fu_ack !== want) begin
      n_fails++;
      $display("FAIL %s fu_ack: got %b expected %b", name, fu_ack, want);
    end
    n_checks++;
    if (select_flag !== (|want)) begin
      n_fails++;
      $display("FAIL %s select_flag: got %b expected %b", name, select_flag, |want);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset_n   = 1'b0;
    fu_req    = 5'b00000;
    cdb_stall = 1'b0;
    squash    = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] want;
    reset_n   = 1'b0;
    fu_req    = 5'b11111;
    cdb_stall = 1'b0;
    squash    = 1'b0;
    @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (select_signal !== 5'b00000 || select_flag !== 1'b0 || fu_ack !== 5'b00000) begin
      n_fails++;
      $display("FAIL reset_outputs: got sel=%b flag=%b ack=%b expected 00000/0/00000",
               select_signal, select_flag, fu_ack);
    end
    n_checks++;
    if (starve_flag !== 5'b00000) begin
      n_fails++;
      $display("FAIL reset_starve: got %b expected 00000", starve_flag);
    end
    reset_n = 1'b1;
    exp_q.push_back(5'b00001);
    #1;
    want = exp_q.pop_front();
    n_checks++;
    if (select_signal !== want) begin
      n_fails++;
      $display("FAIL reset_release_grant: got %b expected %b", select_signal, want);
    end
    // Reset must force outputs low asynchronously, mid-cycle.
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (select_signal !== 5'b00000 || select_flag !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_async: got sel=%b flag=%b expected 00000/0", select_signal, select_flag);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_full_load();
    logic [4:0] seq [6];
    seq = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      step(5'b11111, 1'b0, 1'b0, seq[i], "full_load");
      n_checks++;
      if (starve_flag !== 5'b00000) begin
        n_fails++;
        $display("FAIL full_load_starve: got %b expected 00000", starve_flag);
      end
    end
  endtask

  task automatic test_lone_requester();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      step(5'b01000, 1'b0, 1'b0, 5'b01000, "lone");
    end
  endtask

  task automatic test_stall_saturation();
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      step(5'b00110, 1'b1, 1'b0, 5'b00000, "stall");
    end
    n_checks++;
    if (starve_flag !== 5'b00000) begin
      n_fails++;
      $display("FAIL stall_pre_saturation: got %b expected 00000", starve_flag);
    end
    step(5'b00110, 1'b1, 1'b0, 5'b00000, "stall");
    n_checks++;
    if (starve_flag !== 5'b00110) begin
      n_fails++;
      $display("FAIL stall_saturated: got %b expected 00110", starve_flag);
    end
    step(5'b00110, 1'b0, 1'b0, 5'b00010, "stall_release1");
    n_checks++;
    if (starve_flag !== 5'b00100) begin
      n_fails++;
      $display("FAIL stall_starve_after1: got %b expected 00100", starve_flag);
    end
    step(5'b00100, 1'b0, 1'b0, 5'b00100, "stall_release2");
    n_checks++;
    if (starve_flag !== 5'b00000) begin
      n_fails++;
      $display("FAIL stall_starve_after2: got %b expected 00000", starve_flag);
    end
  endtask

  task automatic test_override();
    apply_reset();
    step(5'b00100, 1'b0, 1'b0, 5'b00100, "ovr_setup");
    for (int i = 0; i < 14; i++) begin
      step(5'b00010, 1'b1, 1'b0, 5'b00000, "ovr_stall");
    end
    step(5'b01010, 1'b1, 1'b0, 5'b00000, "ovr_stall_last");
    step(5'b01010, 1'b0, 1'b0, 5'b00010, "ovr_grant");
    step(5'b01000, 1'b0, 1'b0, 5'b01000, "ovr_next");
    // Pointer now 4: FU0 and FU4 competing must pick FU4.
    step(5'b10001, 1'b0, 1'b0, 5'b10000, "ovr_ptr_after");
  endtask

  task automatic test_squash();
    apply_reset();
    step(5'b01000, 1'b0, 1'b0, 5'b01000, "sq_setup");
    step(5'b10100, 1'b1, 1'b0, 5'b00000, "sq_stall");
    step(5'b10100, 1'b1, 1'b0, 5'b00000, "sq_stall");
    step(5'b10100, 1'b0, 1'b1, 5'b00000, "sq_squash");
    step(5'b10100, 1'b0, 1'b0, 5'b00100, "sq_after");
    // Squash with stall clears the counters: 14 more stalls must not saturate.
    step(5'b00010, 1'b1, 1'b0, 5'b00000, "sq_pre");
    step(5'b00010, 1'b1, 1'b1, 5'b00000, "sq_stall_squash");
    for (int i = 0; i < 14; i++) begin
      step(5'b00010, 1'b1, 1'b0, 5'b00000, "sq_restall");
    end
    n_checks++;
    if (starve_flag !== 5'b00000) begin
      n_fails++;
      $display("FAIL squash_counter_clear: got %b expected 00000", starve_flag);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    step(5'b10001, 1'b0, 1'b0, 5'b00001, "b2b");
    step(5'b10001, 1'b0, 1'b0, 5'b10000, "b2b");
    step(5'b10001, 1'b0, 1'b0, 5'b00001, "b2b");
    step(5'b00000, 1'b0, 1'b0, 5'b00000, "b2b_idle");
    step(5'b00011, 1'b0, 1'b0, 5'b00010, "b2b");
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    reset_n   = 1'b0;
    fu_req    = 5'b00000;
    cdb_stall = 1'b0;
    squash    = 1'b0;
    #2;
    test_reset();
    test_full_load();
    test_lone_requester();
    test_stall_saturation();
    test_override();
    test_squash();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
